blackparrot_fpga_host_csr: RTL and testbench
============================================

Name: blackparrot_fpga_host_csr

Overview:
Parametrised CSR engine between the host AXI-Lite FIFO client and BlackParrot's host-side streams.
- Decodes FIFO-style CSR requests.
- Assembles multi-flit NBF packets.
- Buffers host-to-BP MMIO words and BP-to-host MMIO words.
- Reports occupancy plus sticky error status.
- Next-generation host block: widths, depths and NBF geometry are parameters. Adds W1C status and defined bad-address and underflow behaviour.

Parameters:
- csr_data_width_p, 32, CSR data width; also the width of host-to-BP and BP-to-host words.
- csr_addr_width_p, 64, CSR request address width; only bits [7:0] are decoded.
- nbf_opcode_width_p, 8, NBF opcode width.
- nbf_addr_width_p, 64, NBF address width.
- nbf_data_width_p, 64, NBF data width.
- h2b_els_p, 4, host-to-BP FIFO depth (>=2).
- b2h_els_p, 16, BP-to-host FIFO depth (>=2).

Derived:
- nbf_width_lp = opcode + addr + data widths.
- nbf_flits_lp = ceil(nbf_width_lp / csr_data_width_p); 5 at defaults.
- cnt_w_lp = clog2(b2h_els_p + 1).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- csr_v_i  in  1  CSR request valid
- csr_w_i  in  1  1 = write, 0 = read
- csr_addr_i  in  csr_addr_width_p  byte address
- csr_data_i  in  csr_data_width_p  write data
- csr_wmask_i  in  csr_data_width_p/8  byte mask; ignored by this block
- csr_ready_and_o  out  1  request accepted when csr_v_i & csr_ready_and_o
- csr_data_o  out  csr_data_width_p  read response data
- csr_v_o  out  1  read response valid
- csr_ready_and_i  in  1  response consumed
- nbf_o  out  nbf_width_lp  packet {opcode, addr, data}, data in the LSBs
- nbf_v_o  out  1  packet valid
- nbf_ready_and_i  in  1  packet consumed
- h2b_data_o  out  csr_data_width_p  host-to-BP word
- h2b_v_o  out  1  host-to-BP word valid
- h2b_ready_and_i  in  1  host-to-BP word consumed
- b2h_data_i  in  csr_data_width_p  BP-to-host word
- b2h_v_i  in  1  BP-to-host word valid
- b2h_ready_and_o  out  1  BP-to-host FIFO not full

Behaviour:
- Single clock clk_i. reset_i is synchronous and active-high.
- Reset state:
  - state = IDLE, flit index = 0.
  - Both FIFOs empty; status bits = 0.
  - All valid outputs = 0; csr_data_o = 0.
  - A reset mid-operation drops partial NBF flits, any pending response and all buffered words.

CSR map (addr[7:0]):
- 0x00 NBF (write):
  - flit k is stored at packet bits [k*csr_data_width_p +: csr_data_width_p]; last flit truncated.
  - On flit nbf_flits_lp-1: index returns to 0 and state moves to NBF_SEND.
- 0x04 H2B (write): pushes csr_data_i into the h2b FIFO.
- 0x08 B2H_CNT (read): b2h occupancy, zero-extended; value sampled at the accept cycle.
- 0x0C B2H (read): pops the b2h head. If empty, returns 0 and sets status[1] (underflow).
- 0x10 STATUS:
  - read: {0, flit_index, underflow, bad_addr}; bad_addr = bit 0, underflow = bit 1, flit_index from bit 2 up.
  - write: W1C on bits [1:0].
- Any other address, or a read of 0x00/0x04:
  - sets status[0] (bad_addr).
  - write is dropped; read returns 0.

FSM:
- IDLE: csr_ready_and_o = ~h2b_full.
  - Accepted read -> RESP; csr_data_o is registered in that cycle.
  - Accepted final NBF flit -> NBF_SEND.
  - Any other accepted request stays in IDLE.
- RESP: csr_v_o = 1, csr_ready_and_o = 0. csr_ready_and_i -> IDLE.
- NBF_SEND: nbf_v_o = 1, csr_ready_and_o = 0. nbf_ready_and_i -> IDLE.

Timing and boundary rules:
- Read latency: accepted in cycle N, csr_v_o high in N+1. Data is held stable until consumed.
- csr_ready_and_o never depends combinationally on csr_v_i, csr_w_i or csr_addr_i.
- b2h FIFO:
  - enqueue on b2h_v_i & b2h_ready_and_o.
  - enqueue and pop in the same cycle leave the count unchanged.
  - count saturates at b2h_els_p, where b2h_ready_and_o = 0.
  - a pop while empty never corrupts the count.
- h2b FIFO:
  - h2b_v_o = ~empty.
  - full stalls all CSR requests until space frees (documented back-pressure).
- Simultaneous W1C and a new error on the same bit: the set wins.
- nbf_o is stable while nbf_v_o is high.

Test Plan:
1. Reset, then read 0x08 and 0x10 -> both responses 0, each returned 1 cycle after accept.
2. Write 0x00 five times with 0x11111111..0x55555555 -> nbf_v_o; nbf_o = 0x55_44444444_33333333_22222222_11111111 truncated to 136 bits (opcode 0x55); status flit_index 1..4 between writes, 0 after.
3. Hold nbf_ready_and_i = 0 for 10 cycles during NBF_SEND -> csr_ready_and_o = 0 and nbf_o stable; release -> IDLE, next CSR request accepted.
4. Push 16 b2h words 0..15 -> b2h_ready_and_o = 0 and CNT reads 16; B2H reads return 0..15 in order; a 17th read returns 0 with status = 0x2; write 0x10 with 0x2 -> status = 0.
5. Hold h2b_ready_and_i = 0 and write 0x04 four times -> csr_ready_and_o drops; one h2b pop -> exactly one further request accepted.
6. Write 0x40 -> bad_addr set. Assert reset_i after 2 NBF flits -> flit index 0; the next 5 flits produce a correct packet.

Source files
------------

// File: rtl/blackparrot_fpga_host_csr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blackparrot_fpga_host_csr: CSR engine between host FIFO client and BP     |
// | host-side streams (NBF assembly, h2b/b2h MMIO buffers, W1C status).        |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module blackparrot_fpga_host_csr #(
  parameter int csr_data_width_p   = 32,
  parameter int csr_addr_width_p   = 64,
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 64,
  parameter int nbf_data_width_p   = 64,
  parameter int h2b_els_p          = 4,
  parameter int b2h_els_p          = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  csr_v_i,
  input  logic                                  csr_w_i,
  input  logic [csr_addr_width_p-1:0]           csr_addr_i,
  input  logic [csr_data_width_p-1:0]           csr_data_i,
  input  logic [csr_data_width_p/8-1:0]         csr_wmask_i,
  output logic                                  csr_ready_and_o,
  output logic [csr_data_width_p-1:0]           csr_data_o,
  output logic                                  csr_v_o,
  input  logic                                  csr_ready_and_i,
  output logic [nbf_opcode_width_p+nbf_addr_width_p+nbf_data_width_p-1:0] nbf_o,
  output logic                                  nbf_v_o,
  input  logic                                  nbf_ready_and_i,
  output logic [csr_data_width_p-1:0]           h2b_data_o,
  output logic                                  h2b_v_o,
  input  logic                                  h2b_ready_and_i,
  input  logic [csr_data_width_p-1:0]           b2h_data_i,
  input  logic                                  b2h_v_i,
  output logic                                  b2h_ready_and_o
);

  localparam int nbf_width_lp     = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int nbf_flits_lp     = (nbf_width_lp + csr_data_width_p - 1) / csr_data_width_p;
  localparam int nbf_buf_w_lp     = nbf_flits_lp * csr_data_width_p;
  localparam int idx_w_lp         = $clog2(nbf_flits_lp);
  localparam int cnt_w_lp         = $clog2(b2h_els_p + 1);
  localparam int b2h_ptr_w_lp     = $clog2(b2h_els_p);
  localparam int h2b_cnt_w_lp     = $clog2(h2b_els_p + 1);
  localparam int h2b_ptr_w_lp     = $clog2(h2b_els_p);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESP     = 2'd1,
    ST_NBF_SEND = 2'd2
  } state_e;

  state_e                        state_r;
  logic [idx_w_lp-1:0]           flit_idx_r;
  logic [nbf_buf_w_lp-1:0]       nbf_buf_r;
  logic                          bad_addr_r;
  logic                          underflow_r;
  logic [csr_data_width_p-1:0]   resp_data_r;

  logic [csr_data_width_p-1:0]   h2b_mem [h2b_els_p];
  logic [h2b_ptr_w_lp-1:0]       h2b_rd_ptr_r;
  logic [h2b_ptr_w_lp-1:0]       h2b_wr_ptr_r;
  logic [h2b_cnt_w_lp-1:0]       h2b_cnt_r;

  logic [csr_data_width_p-1:0]   b2h_mem [b2h_els_p];
  logic [b2h_ptr_w_lp-1:0]       b2h_rd_ptr_r;
  logic [b2h_ptr_w_lp-1:0]       b2h_wr_ptr_r;
  logic [cnt_w_lp-1:0]           b2h_cnt_r;

  logic [7:0] addr_lo;
  logic is_nbf, is_h2b, is_cnt, is_b2h, is_status, unmapped;
  logic accept, rd_accept, nbf_wr, last_flit, h2b_push, h2b_pop, h2b_full;
  logic status_w1c, bad_set, underflow_set;
  logic b2h_full, b2h_empty, b2h_enq, b2h_pop, b2h_pop_req;
  logic [csr_data_width_p-1:0] status_word;
  logic [csr_data_width_p-1:0] rd_data;
  logic unused_bits;

  assign addr_lo   = csr_addr_i[7:0];
  assign is_nbf    = (addr_lo == 8'h00);
  assign is_h2b    = (addr_lo == 8'h04);
  assign is_cnt    = (addr_lo == 8'h08);
  assign is_b2h    = (addr_lo == 8'h0C);
  assign is_status = (addr_lo == 8'h10);
  assign unmapped  = ~(is_nbf | is_h2b | is_cnt | is_b2h | is_status);

  // Ready is a function of registered state only, never of the request itself.
  assign h2b_full        = (h2b_cnt_r == h2b_cnt_w_lp'(h2b_els_p));
  assign csr_ready_and_o = (state_r == ST_IDLE) & ~h2b_full;
  assign accept          = csr_v_i & csr_ready_and_o;
  assign rd_accept       = accept & ~csr_w_i;

  assign nbf_wr     = accept & csr_w_i & is_nbf;
  assign last_flit  = (flit_idx_r == idx_w_lp'(nbf_flits_lp - 1));
  assign h2b_push   = accept & csr_w_i & is_h2b;
  assign status_w1c = accept & csr_w_i & is_status;
  assign bad_set    = accept & (unmapped | (~csr_w_i & (is_nbf | is_h2b)));

  assign b2h_empty       = (b2h_cnt_r == '0);
  assign b2h_full        = (b2h_cnt_r == cnt_w_lp'(b2h_els_p));
  assign b2h_ready_and_o = ~b2h_full;
  assign b2h_enq         = b2h_v_i & ~b2h_full;
  assign b2h_pop_req     = rd_accept & is_b2h;
  assign b2h_pop         = b2h_pop_req & ~b2h_empty;
  assign underflow_set   = b2h_pop_req & b2h_empty;

  assign h2b_v_o    = (h2b_cnt_r != '0);
  assign h2b_data_o = h2b_mem[h2b_rd_ptr_r];
  assign h2b_pop    = h2b_v_o & h2b_ready_and_i;

  assign csr_v_o    = (state_r == ST_RESP);
  assign nbf_v_o    = (state_r == ST_NBF_SEND);
  assign csr_data_o = resp_data_r;
  assign nbf_o      = nbf_buf_r[nbf_width_lp-1:0];

  assign unused_bits = ^{csr_wmask_i, csr_addr_i[csr_addr_width_p-1:8]};

  generate
    if (nbf_buf_w_lp > nbf_width_lp) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^nbf_buf_r[nbf_buf_w_lp-1:nbf_width_lp];
    end
  endgenerate

  always_comb begin
    status_word = '0;
    status_word[0] = bad_addr_r;
    status_word[1] = underflow_r;
    status_word[2 +: idx_w_lp] = flit_idx_r;
  end

  always_comb begin
    rd_data = '0;
    if (is_cnt) begin
      rd_data[cnt_w_lp-1:0] = b2h_cnt_r;
    end else if (is_b2h && !b2h_empty) begin
      rd_data = b2h_mem[b2h_rd_ptr_r];
    end else if (is_status) begin
      rd_data = status_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      flit_idx_r  <= '0;
      nbf_buf_r   <= '0;
      bad_addr_r  <= 1'b0;
      underflow_r <= 1'b0;
      resp_data_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rd_accept) begin
            state_r     <= ST_RESP;
            resp_data_r <= rd_data;
          end else if (nbf_wr && last_flit) begin
            state_r <= ST_NBF_SEND;
          end
        end
        ST_RESP:     if (csr_ready_and_i) state_r <= ST_IDLE;
        ST_NBF_SEND: if (nbf_ready_and_i) state_r <= ST_IDLE;
        default:     state_r <= ST_IDLE;
      endcase

      if (nbf_wr) begin
        nbf_buf_r[flit_idx_r*csr_data_width_p +: csr_data_width_p] <= csr_data_i;
        flit_idx_r <= last_flit ? '0 : flit_idx_r + 1'b1;
      end

      // A new error in the same cycle as its W1C wins over the clear.
      bad_addr_r  <= (bad_addr_r  & ~(status_w1c & csr_data_i[0])) | bad_set;
      underflow_r <= (underflow_r & ~(status_w1c & csr_data_i[1])) | underflow_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (h2b_push) h2b_mem[h2b_wr_ptr_r] <= csr_data_i;
    if (b2h_enq)  b2h_mem[b2h_wr_ptr_r] <= b2h_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h2b_rd_ptr_r <= '0;
      h2b_wr_ptr_r <= '0;
      h2b_cnt_r    <= '0;
    end else begin
      if (h2b_push)
        h2b_wr_ptr_r <= (h2b_wr_ptr_r == h2b_ptr_w_lp'(h2b_els_p - 1)) ? '0 : h2b_wr_ptr_r + 1'b1;
      if (h2b_pop)
        h2b_rd_ptr_r <= (h2b_rd_ptr_r == h2b_ptr_w_lp'(h2b_els_p - 1)) ? '0 : h2b_rd_ptr_r + 1'b1;
      case ({h2b_push, h2b_pop})
        2'b10:   h2b_cnt_r <= h2b_cnt_r + 1'b1;
        2'b01:   h2b_cnt_r <= h2b_cnt_r - 1'b1;
        default: h2b_cnt_r <= h2b_cnt_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      b2h_rd_ptr_r <= '0;
      b2h_wr_ptr_r <= '0;
      b2h_cnt_r    <= '0;
    end else begin
      if (b2h_enq)
        b2h_wr_ptr_r <= (b2h_wr_ptr_r == b2h_ptr_w_lp'(b2h_els_p - 1)) ? '0 : b2h_wr_ptr_r + 1'b1;
      if (b2h_pop)
        b2h_rd_ptr_r <= (b2h_rd_ptr_r == b2h_ptr_w_lp'(b2h_els_p - 1)) ? '0 : b2h_rd_ptr_r + 1'b1;
      case ({b2h_enq, b2h_pop})
        2'b10:   b2h_cnt_r <= b2h_cnt_r + 1'b1;
        2'b01:   b2h_cnt_r <= b2h_cnt_r - 1'b1;
        default: b2h_cnt_r <= b2h_cnt_r;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blackparrot_fpga_host_csr.sv
`default_nettype none
// Testbench for blackparrot_fpga_host_csr: queue-level reference model feeding a scoreboard monitor.
module tb_blackparrot_fpga_host_csr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1;
  logic          csr_v_i = 1'b0, csr_w_i = 1'b0;
  logic [63:0]   csr_addr_i = '0;
  logic [31:0]   csr_data_i = '0;
  logic [3:0]    csr_wmask_i = '0;
  logic          csr_ready_and_o, csr_v_o;
  logic [31:0]   csr_data_o;
  logic          csr_ready_and_i = 1'b0;
  logic [135:0]  nbf_o;
  logic          nbf_v_o;
  logic          nbf_ready_and_i = 1'b0;
  logic [31:0]   h2b_data_o;
  logic          h2b_v_o;
  logic          h2b_ready_and_i = 1'b0;
  logic [31:0]   b2h_data_i = '0;
  logic          b2h_v_i = 1'b0;
  logic          b2h_ready_and_o;

  blackparrot_fpga_host_csr dut (
    .clk_i(clk), .reset_i(reset_i),
    .csr_v_i(csr_v_i), .csr_w_i(csr_w_i), .csr_addr_i(csr_addr_i),
    .csr_data_i(csr_data_i), .csr_wmask_i(csr_wmask_i),
    .csr_ready_and_o(csr_ready_and_o), .csr_data_o(csr_data_o),
    .csr_v_o(csr_v_o), .csr_ready_and_i(csr_ready_and_i),
    .nbf_o(nbf_o), .nbf_v_o(nbf_v_o), .nbf_ready_and_i(nbf_ready_and_i),
    .h2b_data_o(h2b_data_o), .h2b_v_o(h2b_v_o), .h2b_ready_and_i(h2b_ready_and_i),
    .b2h_data_i(b2h_data_i), .b2h_v_i(b2h_v_i), .b2h_ready_and_o(b2h_ready_and_o)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: filled by the stimulus side, drained by the monitor.
  logic [31:0]  exp_resp [$];
  logic [135:0] exp_nbf  [$];
  logic [31:0]  exp_h2b  [$];

  // Per-cycle expectations published by the stimulus side.
  bit e_on = 0, e_ready, e_csrv, e_nbfv, e_b2hrdy, e_h2bv, post_rst = 0;
  int to_cnt = 0, to_seen = 0;

  // Reference model state.
  int          m_st = 0;          // 0 idle, 1 response pending, 2 packet pending
  int          m_h2b_n = 0;
  logic [31:0] m_b2h [$];
  logic [31:0] m_flit [5];
  int          m_idx = 0;
  bit          m_bad = 0, m_uf = 0;

  // Pending stimulus and handshake modes (0 low, 1 high, 2 random).
  bit          p_v = 0, p_w = 0, p_rst = 1;
  logic [63:0] p_addr = '0;
  logic [31:0] p_data = '0;
  int crdy_mode = 2, nrdy_mode = 2, hrdy_mode = 2, b2h_mode = 0;
  int b2h_seq = 0;
  bit last_acc = 0, just_rst = 0;

  task automatic chk(string name, logic [135:0] act, logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!reset_i && e_on) begin
      chk("csr_ready", csr_ready_and_o, e_ready);
      chk("csr_v", csr_v_o, e_csrv);
      chk("nbf_v", nbf_v_o, e_nbfv);
      chk("b2h_ready", b2h_ready_and_o, e_b2hrdy);
      chk("h2b_v", h2b_v_o, e_h2bv);
      if (post_rst) chk("reset_csr_data", csr_data_o, 136'd0);
      if (csr_v_o) begin
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected actual=%0h expected=none", csr_data_o);
        end else begin
          chk("resp_data", csr_data_o, exp_resp[0]);
          if (csr_ready_and_i) void'(exp_resp.pop_front());
        end
      end
      if (nbf_v_o) begin
        if (exp_nbf.size() == 0) begin
          checks++; errors++;
          $display("FAIL nbf_unexpected actual=%0h expected=none", nbf_o);
        end else begin
          chk("nbf_pkt", nbf_o, exp_nbf[0]);
          if (nbf_ready_and_i) void'(exp_nbf.pop_front());
        end
      end
      if (h2b_v_o) begin
        if (exp_h2b.size() == 0) begin
          checks++; errors++;
          $display("FAIL h2b_unexpected actual=%0h expected=none", h2b_data_o);
        end else begin
          chk("h2b_data", h2b_data_o, exp_h2b[0]);
          if (h2b_ready_and_i) void'(exp_h2b.pop_front());
        end
      end
    end
    if (to_cnt != to_seen) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted count=%0d", to_cnt);
      to_seen = to_cnt;
    end
  end

  function automatic bit pick(int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One clock of stimulus: publish expectations for the current state,
  // drive inputs, then advance the model across the coming edge.
  task automatic tick();
    bit acc, enq, hpop, rdy;
    logic [31:0]  rv;
    logic [7:0]   a;
    logic [159:0] full;
    @(negedge clk);
    csr_ready_and_i = pick(crdy_mode);
    nbf_ready_and_i = pick(nrdy_mode);
    h2b_ready_and_i = pick(hrdy_mode);
    case (b2h_mode)
      0: b2h_v_i = 1'b0;
      1: begin b2h_v_i = 1'($urandom_range(0, 1)); b2h_data_i = $urandom; end
      default: begin b2h_v_i = (b2h_seq < 16); b2h_data_i = 32'(b2h_seq); end
    endcase
    csr_v_i = p_v; csr_w_i = p_w; csr_addr_i = p_addr; csr_data_i = p_data;
    csr_wmask_i = 4'($urandom);
    reset_i = p_rst;
    if (p_rst) begin
      m_st = 0; m_h2b_n = 0; m_b2h.delete(); m_idx = 0; m_bad = 0; m_uf = 0;
      exp_resp.delete(); exp_nbf.delete(); exp_h2b.delete();
      e_on = 0; last_acc = 0; just_rst = 1;
      return;
    end
    rdy = (m_st == 0) && (m_h2b_n < 4);
    e_on = 1; e_ready = rdy; e_csrv = (m_st == 1); e_nbfv = (m_st == 2);
    e_b2hrdy = (m_b2h.size() < 16); e_h2bv = (m_h2b_n > 0);
    post_rst = just_rst; just_rst = 0;

    acc  = p_v && rdy;
    last_acc = acc;
    enq  = b2h_v_i && (m_b2h.size() < 16);
    hpop = (m_h2b_n > 0) && h2b_ready_and_i;
    if (m_st == 1 && csr_ready_and_i) m_st = 0;
    else if (m_st == 2 && nbf_ready_and_i) m_st = 0;

    if (acc) begin
      a = p_addr[7:0];
      if (p_w) begin
        case (a)
          8'h00: begin
            m_flit[m_idx] = p_data;
            if (m_idx == 4) begin
              for (int k = 0; k < 5; k++) full[k*32 +: 32] = m_flit[k];
              exp_nbf.push_back(full[135:0]);
              m_idx = 0; m_st = 2;
            end else m_idx++;
          end
          8'h04: begin m_h2b_n++; exp_h2b.push_back(p_data); end
          8'h08, 8'h0C: ;
          8'h10: begin if (p_data[0]) m_bad = 0; if (p_data[1]) m_uf = 0; end
          default: m_bad = 1;
        endcase
      end else begin
        case (a)
          8'h08: rv = 32'(m_b2h.size());
          8'h0C: begin
            if (m_b2h.size() > 0) rv = m_b2h.pop_front();
            else begin rv = 0; m_uf = 1; end
          end
          8'h10: rv = 32'(m_idx * 4 + int'(m_uf) * 2 + int'(m_bad));
          default: begin rv = 0; m_bad = 1; end
        endcase
        exp_resp.push_back(rv);
        m_st = 1;
      end
    end
    if (hpop) m_h2b_n--;
    if (enq) begin
      m_b2h.push_back(b2h_data_i);
      if (b2h_mode == 2) b2h_seq++;
    end
  endtask

  task automatic csr_req(bit w, logic [7:0] a, logic [31:0] d);
    p_v = 1; p_w = w; p_addr = {$urandom, $urandom}; p_addr[7:0] = a; p_data = d;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) to_cnt++;
    p_v = 0;
  endtask

  task automatic do_reset(int n);
    p_v = 0; p_rst = 1;
    repeat (n) tick();
    p_rst = 0;
  endtask

  initial begin
    // Reset state and first reads.
    do_reset(3);
    tick();
    csr_req(0, 8'h08, 0);
    csr_req(0, 8'h10, 0);

    // Five-flit packet with status reads in between.
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) nrdy_mode = 0;
      csr_req(1, 8'h00, 32'h11111111 * k);
      if (k < 5) csr_req(0, 8'h10, 0);
    end
    // Packet held for 10 cycles with a request waiting.
    p_v = 1; p_w = 0; p_addr = 64'h08;
    repeat (10) tick();
    nrdy_mode = 1;
    csr_req(0, 8'h10, 0);
    nrdy_mode = 2;

    // Fill b2h to capacity, drain it, underflow, then W1C.
    b2h_mode = 2; b2h_seq = 0;
    for (int i = 0; i < 200 && b2h_seq < 16; i++) tick();
    b2h_mode = 0;
    tick();
    csr_req(0, 8'h08, 0);
    for (int i = 0; i < 17; i++) csr_req(0, 8'h0C, 0);
    csr_req(0, 8'h10, 0);
    csr_req(1, 8'h10, 32'h2);
    csr_req(0, 8'h10, 0);

    // h2b back-pressure: full stalls requests, one pop admits exactly one.
    hrdy_mode = 1; repeat (10) tick();
    hrdy_mode = 0;
    for (int i = 0; i < 4; i++) csr_req(1, 8'h04, $urandom);
    p_v = 1; p_w = 1; p_addr = 64'h04;
    for (int i = 0; i < 5; i++) begin p_data = $urandom; tick(); end
    hrdy_mode = 1; tick();
    hrdy_mode = 0;
    for (int i = 0; i < 6; i++) begin p_data = $urandom; tick(); end
    p_v = 0; hrdy_mode = 2; repeat (10) tick();

    // Bad address, then reset in the middle of a packet.
    csr_req(1, 8'h40, 32'hDEAD);
    csr_req(0, 8'h10, 0);
    csr_req(1, 8'h10, 32'h3);
    csr_req(1, 8'h00, 32'hAAAA0001);
    csr_req(1, 8'h00, 32'hAAAA0002);
    do_reset(2);
    tick();
    csr_req(0, 8'h10, 0);
    for (int k = 0; k < 5; k++) csr_req(1, 8'h00, $urandom);
    csr_req(0, 8'h10, 0);

    // Randomized traffic against the model.
    b2h_mode = 1;
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [7:0] bad_a [4];
      bad_a[0] = 8'h14; bad_a[1] = 8'h40; bad_a[2] = 8'hFC; bad_a[3] = 8'h02;
      crdy_mode = 2; nrdy_mode = 2; hrdy_mode = 2;
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2: csr_req(1, 8'h00, $urandom);
        3:  csr_req(1, 8'h04, $urandom);
        4:  csr_req(0, 8'h08, 0);
        5:  csr_req(0, 8'h0C, 0);
        6:  csr_req(0, 8'h10, 0);
        7:  csr_req(1, 8'h10, $urandom);
        8:  csr_req(1'($urandom_range(0, 1)), bad_a[$urandom_range(0, 3)], $urandom);
        9:  csr_req(0, ($urandom_range(0, 1) != 0) ? 8'h04 : 8'h00, 0);
        default: repeat ($urandom_range(1, 4)) tick();
      endcase
      if ($urandom_range(0, 299) == 0) begin do_reset(1); tick(); end
    end

    b2h_mode = 0; crdy_mode = 1; nrdy_mode = 1; hrdy_mode = 1;
    repeat (30) tick();
    @(negedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
